// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
//   Stopwatch-mode sequencer for the FPGA clock. Two raw push-buttons are
//   synchronized and debounced into single-cycle press events. A four-state
//   FSM turns those events into the enable and clear for the time counter. It
//   also selects a live or a lap-frozen count for the display.
//
//   state | meaning
//   ------+-------------------------------------------------
//   IDLE  | stopped, count cleared or never started
//   RUN   | counting, display shows live count
//   LAP   | counting, display frozen at lap snapshot
//   PAUSE | stopped, display shows the stopped live count
//
// Ports
//   clk             system clock (only clock used)
//   rst_n           asynchronous active-low reset
//   btn_start_stop  raw button, active-high, asynchronous
//   btn_lap_clear   raw button, active-high, asynchronous
//   counter[31:0]   live count from the time counter
//   cnt_en          count enable to the time counter
//   cnt_clr         one-cycle synchronous clear to the time counter
//   display[31:0]   registered value for the display decoder
//   state[1:0]      FSM state: IDLE=0, RUN=1, LAP=2, PAUSE=3
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DB_W            = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_start_stop,
  input  logic        btn_lap_clear,
  input  logic [31:0] counter,
  output logic        cnt_en,
  output logic        cnt_clr,
  output logic [31:0] display,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  // Accept on the edge where the counter would otherwise reach DEBOUNCE_CYCLES.
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  // Bit 0 = start_stop, bit 1 = lap_clear.
  logic [1:0]      btn_raw;
  logic [1:0]      sync1, sync2, db, db_prev, evt;
  logic [DB_W-1:0] db_cnt [2];

  assign btn_raw = {btn_lap_clear, btn_start_stop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      db      <= '0;
      db_prev <= '0;
      evt     <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      db_prev <= db;
      evt     <= db & ~db_prev;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_ONE;
        end
      end
    end
  end

  logic        start_ev, lap_ev;
  state_t      st_q, st_d;
  logic        clr_d, snap_ld;
  logic [31:0] snap, snap_nxt;

  assign start_ev = evt[0];
  assign lap_ev   = evt[1];

  // start_stop is checked first so a simultaneous lap_clear is dropped.
  always_comb begin
    st_d    = st_q;
    clr_d   = 1'b0;
    snap_ld = 1'b0;
    case (st_q)
      IDLE: begin
        if (start_ev)    st_d  = RUN;
        else if (lap_ev) clr_d = 1'b1;
      end
      RUN: begin
        if (start_ev) begin
          st_d = PAUSE;
        end else if (lap_ev) begin
          st_d    = LAP;
          snap_ld = 1'b1;
        end
      end
      LAP: begin
        if (start_ev)    st_d = PAUSE;
        else if (lap_ev) st_d = RUN;
      end
      PAUSE: begin
        if (start_ev) begin
          st_d = RUN;
        end else if (lap_ev) begin
          st_d  = IDLE;
          clr_d = 1'b1;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  // On the LAP-entry edge the snapshot is being loaded, so display must see
  // the incoming value rather than the old snap register.
  assign snap_nxt = snap_ld ? counter : snap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
      snap    <= '0;
      display <= '0;
    end else begin
      st_q    <= st_d;
      cnt_en  <= (st_d == RUN) || (st_d == LAP);
      cnt_clr <= clr_d;
      snap    <= snap_nxt;
      display <= (st_d == LAP) ? snap_nxt : counter;
    end
  end

  assign state = st_q;

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Sequencing controller for the stopwatch mode of the FPGA clock. Two push-buttons are synchronized and debounced into single-cycle press events. A four-state FSM uses those events to drive the time counter's enable and clear. The 32-bit count passed to the seven-segment driver is either live or frozen (lap hold). The block sits between the raw board buttons, the stopwatch time counter and the display decoder.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable clocks required before a button level is accepted (10 ms at 50 MHz); must be ≥ 1.
- DB_W, 20: width of each debounce counter; must satisfy 2^DB_W > DEBOUNCE_CYCLES.
- clk  in  1  system clock; the block uses this one clock only.
- rst_n  in  1  reset, asynchronous and active-low.
- btn_start_stop  in  1  raw button, active-high, asynchronous to clk.
- btn_lap_clear  in  1  raw button, active-high, asynchronous to clk.
- counter  in  32  live count from the stopwatch time counter.
- cnt_en  out  1  count enable to the time counter.
- cnt_clr  out  1  one-cycle synchronous clear pulse to the time counter.
- display  out  32  registered value sent to the display decoder.
- state  out  2  FSM state: IDLE=0, RUN=1, LAP=2, PAUSE=3.

## Operation
- **Per-button front end**
  - Two-flop synchronizer.
  - Debouncer: holds accepted level `db`. Its counter resets to 0 whenever sync2 equals `db`. It increments while sync2 differs from `db`. On the edge where it would reach DEBOUNCE_CYCLES, `db` takes sync2 and the counter clears.
  - Press event: registered `db & ~db_prev`, high exactly one cycle per accepted press. Releases generate no event.
- **FSM, one transition per cycle**
  - IDLE: start_stop → RUN. lap_clear → stay IDLE and pulse cnt_clr.
  - RUN: start_stop → PAUSE. lap_clear → LAP, capturing `snap <= counter` on the transition edge.
  - LAP: start_stop → PAUSE. lap_clear → RUN; display returns to live.
  - PAUSE: start_stop → RUN. lap_clear → IDLE and pulse cnt_clr.
- **Simultaneous events in one cycle:** start_stop wins and the lap_clear event is discarded (not queued).
- **Outputs as registered functions of the next state**
  - cnt_en = 1 in RUN and LAP, 0 otherwise.
  - cnt_clr = 1 for one cycle, on the cycle after the edge that takes a clearing transition.
  - display is updated every edge: `snap` if next state is LAP, else `counter`. PAUSE therefore shows the stopped live count.
- **No arithmetic on the count.** `counter` is passed through or snapshotted unmodified, all 32 bits. Debounce counters never wrap, because they clear at DEBOUNCE_CYCLES.

## Timing
- Reset (asynchronous, any time, including mid-debounce or in LAP):
  - state=IDLE, cnt_en=0, cnt_clr=0, display=0, snap=0.
  - Synchronizers, `db`, `db_prev`, event registers and debounce counters all reset to 0.
  - After release, display tracks counter with 1-cycle latency.
- Press latency, with N = DEBOUNCE_CYCLES and edge 1 the first edge that samples the raw button high:
  - sync2 is high after edge 2.
  - `db` rises at edge N+2.
  - The event is high between edges N+3 and N+4.
  - state, cnt_en and display update at edge N+4.
  - cnt_clr is high for the cycle following edge N+4.
- Glitch rejection: a raw pulse held high for fewer than N sampled cycles produces no event; the debounce counter restarts from 0.
- Holding a button produces exactly one event. The next event needs a release accepted by the debouncer (N stable low cycles), then a new press.
- display lags counter by exactly one clock outside LAP. In LAP it is constant and equals counter as sampled on the LAP-entry edge.
- cnt_en and cnt_clr are never high in the same cycle.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, DB_W=3, with counter driven by a bench incrementer gated by cnt_en and cleared by cnt_clr.
- Reset then idle: display=0 and state=0 during reset. After release, press start_stop for 10 cycles → state=1 and cnt_en=1 at edge 8, and exactly one event.
- Glitch: 3-cycle high pulse on btn_lap_clear in RUN → no state change, cnt_clr never asserted.
- Lap hold: in RUN at counter=0x64, press lap_clear → state=2, display frozen at the captured value while counter keeps increasing. Press lap_clear again → state=1, display = counter one cycle delayed.
- Pause and clear: RUN → start_stop → state=3, cnt_en=0, display static. lap_clear → state=0, one-cycle cnt_clr, counter=0 the next cycle.
- Simultaneous: both buttons raised on the same edge in RUN → state=3, no LAP entry, no queued lap event afterwards.
- Async reset mid-operation: assert rst_n low in LAP between clock edges → all outputs take reset values immediately, without waiting for a clock edge. Presses already in progress in the debouncers at that moment produce no event.
